// File: rtl/uart_ctrl.sv
// Full-duplex 8N1 UART: clock-divided byte transmitter plus a 16x-oversampling receiver.
// With LOOPBACK != 0 the receiver listens to the transmitter's own serial line.
module uart_ctrl #(
   parameter int unsigned CLOCK_RATE    = 25000000,
   parameter int unsigned BAUD_RATE     = 115200,
   parameter int unsigned RX_OVERSAMPLE = 16,
   parameter int unsigned LOOPBACK      = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       i_Tx_Ready,
   input  logic [7:0] i_Tx_Byte,
   output logic       o_Tx_Active,
   output logic       o_Tx_Data,
   output logic       o_Tx_Done,
   input  logic       i_Rx_Data,
   output logic       o_Rx_Done,
   output logic [7:0] o_Rx_Byte
);

   localparam int unsigned CLKS_PER_BIT = CLOCK_RATE / BAUD_RATE;
   localparam int unsigned TX_CNT_W     = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int unsigned OS_W         = $clog2(RX_OVERSAMPLE);
   localparam int unsigned ACC_W        = 32;
   localparam int unsigned SUM_W        = ACC_W + 1;
   localparam int unsigned ACC_INC      = BAUD_RATE * RX_OVERSAMPLE;

   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_ERR} rx_state_t;

   tx_state_t             tx_state, tx_state_nxt;
   logic [TX_CNT_W-1:0]   tx_cnt, tx_cnt_nxt;
   logic [2:0]            tx_bit, tx_bit_nxt;
   logic [7:0]            tx_shift, tx_shift_nxt;
   logic                  tx_data_nxt, tx_active_nxt, tx_done_nxt;

   rx_state_t             rx_state, rx_state_nxt;
   logic [OS_W-1:0]       rx_tcnt, rx_tcnt_nxt;
   logic [2:0]            rx_bit, rx_bit_nxt;
   logic [7:0]            rx_shift, rx_shift_nxt;
   logic [7:0]            rx_byte_nxt;
   logic                  rx_done_nxt;

   logic [ACC_W-1:0]      acc;
   logic [SUM_W-1:0]      sum_c;
   logic                  tick;
   logic                  rx_in_c, rx_meta, rx_sync;

   // Transmitter: outputs are registered from their next-state values
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tx_state    <= TX_IDLE;
         tx_cnt      <= '0;
         tx_bit      <= '0;
         tx_shift    <= '0;
         o_Tx_Data   <= 1'b1;
         o_Tx_Active <= 1'b0;
         o_Tx_Done   <= 1'b0;
      end else begin
         tx_state    <= tx_state_nxt;
         tx_cnt      <= tx_cnt_nxt;
         tx_bit      <= tx_bit_nxt;
         tx_shift    <= tx_shift_nxt;
         o_Tx_Data   <= tx_data_nxt;
         o_Tx_Active <= tx_active_nxt;
         o_Tx_Done   <= tx_done_nxt;
      end
   end

   always_comb begin
      tx_state_nxt  = tx_state;
      tx_cnt_nxt    = tx_cnt;
      tx_bit_nxt    = tx_bit;
      tx_shift_nxt  = tx_shift;
      tx_data_nxt   = o_Tx_Data;
      tx_active_nxt = o_Tx_Active;
      tx_done_nxt   = 1'b0;
      case (tx_state)
         TX_IDLE: begin
            tx_cnt_nxt    = '0;
            tx_data_nxt   = 1'b1;
            tx_active_nxt = 1'b0;
            if (i_Tx_Ready) begin
               tx_shift_nxt  = i_Tx_Byte;
               tx_state_nxt  = TX_START;
               tx_data_nxt   = 1'b0;
               tx_active_nxt = 1'b1;
            end
         end
         TX_START: begin
            if (tx_cnt == TX_CNT_W'(CLKS_PER_BIT - 1)) begin
               tx_cnt_nxt   = '0;
               tx_bit_nxt   = '0;
               tx_data_nxt  = tx_shift[0];
               tx_state_nxt = TX_DATA;
            end else begin
               tx_cnt_nxt = tx_cnt + TX_CNT_W'(1);
            end
         end
         TX_DATA: begin
            if (tx_cnt == TX_CNT_W'(CLKS_PER_BIT - 1)) begin
               tx_cnt_nxt = '0;
               if (tx_bit == 3'd7) begin
                  tx_data_nxt  = 1'b1;
                  tx_state_nxt = TX_STOP;
               end else begin
                  tx_bit_nxt   = tx_bit + 3'd1;
                  tx_data_nxt  = tx_shift[1];
                  tx_shift_nxt = {1'b0, tx_shift[7:1]};
               end
            end else begin
               tx_cnt_nxt = tx_cnt + TX_CNT_W'(1);
            end
         end
         TX_STOP: begin
            // Done is registered, so raise it one clk early to land on the last STOP clk
            if (tx_cnt == TX_CNT_W'(CLKS_PER_BIT - 2)) tx_done_nxt = 1'b1;
            if (tx_cnt == TX_CNT_W'(CLKS_PER_BIT - 1)) begin
               tx_cnt_nxt    = '0;
               tx_data_nxt   = 1'b1;
               tx_active_nxt = 1'b0;
               tx_state_nxt  = TX_IDLE;
            end else begin
               tx_cnt_nxt = tx_cnt + TX_CNT_W'(1);
            end
         end
         default: tx_state_nxt = TX_IDLE;
      endcase
   end

   // Oversample tick: phase accumulator keeps the mean tick rate exact
   assign sum_c = {1'b0, acc} + SUM_W'(ACC_INC);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc  <= '0;
         tick <= 1'b0;
      end else if (sum_c >= SUM_W'(CLOCK_RATE)) begin
         acc  <= ACC_W'(sum_c - SUM_W'(CLOCK_RATE));
         tick <= 1'b1;
      end else begin
         acc  <= ACC_W'(sum_c);
         tick <= 1'b0;
      end
   end

   assign rx_in_c = (LOOPBACK != 0) ? o_Tx_Data : i_Rx_Data;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
      end else begin
         rx_meta <= rx_in_c;
         rx_sync <= rx_meta;
      end
   end

   // Receiver
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_state  <= RX_IDLE;
         rx_tcnt   <= '0;
         rx_bit    <= '0;
         rx_shift  <= '0;
         o_Rx_Byte <= 8'h00;
         o_Rx_Done <= 1'b0;
      end else begin
         rx_state  <= rx_state_nxt;
         rx_tcnt   <= rx_tcnt_nxt;
         rx_bit    <= rx_bit_nxt;
         rx_shift  <= rx_shift_nxt;
         o_Rx_Byte <= rx_byte_nxt;
         o_Rx_Done <= rx_done_nxt;
      end
   end

   always_comb begin
      rx_state_nxt = rx_state;
      rx_tcnt_nxt  = rx_tcnt;
      rx_bit_nxt   = rx_bit;
      rx_shift_nxt = rx_shift;
      rx_byte_nxt  = o_Rx_Byte;
      rx_done_nxt  = 1'b0;
      case (rx_state)
         RX_IDLE: begin
            if (tick && !rx_sync) begin
               rx_tcnt_nxt  = '0;
               rx_state_nxt = RX_START;
            end
         end
         RX_START: begin
            if (tick) begin
               if (rx_tcnt == OS_W'(RX_OVERSAMPLE / 2 - 1)) begin
                  rx_tcnt_nxt  = '0;
                  rx_bit_nxt   = '0;
                  rx_state_nxt = rx_sync ? RX_IDLE : RX_DATA;
               end else begin
                  rx_tcnt_nxt = rx_tcnt + OS_W'(1);
               end
            end
         end
         RX_DATA: begin
            if (tick) begin
               if (rx_tcnt == OS_W'(RX_OVERSAMPLE - 1)) begin
                  rx_tcnt_nxt  = '0;
                  rx_shift_nxt = {rx_sync, rx_shift[7:1]};
                  if (rx_bit == 3'd7) rx_state_nxt = RX_STOP;
                  else                rx_bit_nxt   = rx_bit + 3'd1;
               end else begin
                  rx_tcnt_nxt = rx_tcnt + OS_W'(1);
               end
            end
         end
         RX_STOP: begin
            if (tick) begin
               if (rx_tcnt == OS_W'(RX_OVERSAMPLE - 1)) begin
                  rx_tcnt_nxt = '0;
                  if (rx_sync) begin
                     rx_byte_nxt  = rx_shift;
                     rx_done_nxt  = 1'b1;
                     rx_state_nxt = RX_IDLE;
                  end else begin
                     rx_state_nxt = RX_ERR;
                  end
               end else begin
                  rx_tcnt_nxt = rx_tcnt + OS_W'(1);
               end
            end
         end
         RX_ERR: begin
            // Framing error: hold off until the line is idle again
            if (rx_sync) rx_state_nxt = RX_IDLE;
         end
         default: rx_state_nxt = RX_IDLE;
      endcase
   end

endmodule

// File: tb/tb_uart_ctrl.sv
// Bench for uart_ctrl: one loopback instance and one external-line instance, checked
// against frame-level expectations built from the 8N1 format and baud arithmetic.
module tb_uart_ctrl;
   localparam int unsigned CPB    = 217;
   localparam int unsigned FRAME  = 10 * CPB;
   localparam int unsigned BIT_NS = 8680;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #20 clk = ~clk;

   logic       lb_ready = 1'b0, lb_rxin = 1'b0;
   logic [7:0] lb_byte = 8'h00;
   logic       lb_active, lb_txd, lb_txdone, lb_rxdone;
   logic [7:0] lb_rxbyte;

   logic       ext_ready = 1'b0, ext_rxin = 1'b1;
   logic [7:0] ext_byte = 8'h00;
   logic       ext_active, ext_txd, ext_txdone, ext_rxdone;
   logic [7:0] ext_rxbyte;

   uart_ctrl #(.CLOCK_RATE(25000000), .BAUD_RATE(115200), .RX_OVERSAMPLE(16), .LOOPBACK(1)) u_lb (
      .clk(clk), .reset(reset), .i_Tx_Ready(lb_ready), .i_Tx_Byte(lb_byte),
      .o_Tx_Active(lb_active), .o_Tx_Data(lb_txd), .o_Tx_Done(lb_txdone),
      .i_Rx_Data(lb_rxin), .o_Rx_Done(lb_rxdone), .o_Rx_Byte(lb_rxbyte));

   uart_ctrl #(.CLOCK_RATE(25000000), .BAUD_RATE(115200), .RX_OVERSAMPLE(16), .LOOPBACK(0)) u_ext (
      .clk(clk), .reset(reset), .i_Tx_Ready(ext_ready), .i_Tx_Byte(ext_byte),
      .o_Tx_Active(ext_active), .o_Tx_Data(ext_txd), .o_Tx_Done(ext_txdone),
      .i_Rx_Data(ext_rxin), .o_Rx_Done(ext_rxdone), .o_Rx_Byte(ext_rxbyte));

   int compared = 0;
   int mismatched = 0;
   int unsigned cyc = 0;
   int lb_rx_cnt = 0;
   int ext_rx_cnt = 0;

   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) begin
      if (lb_rxdone)  lb_rx_cnt  <= lb_rx_cnt + 1;
      if (ext_rxdone) ext_rx_cnt <= ext_rx_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Bit j of an 8N1 frame: 0 = start, 1..8 = data LSB first, 9 = stop
   function automatic logic frame_bit(input logic [7:0] b, input int j);
      logic [9:0] f;
      f = {1'b1, b, 1'b0};
      return f[j];
   endfunction

   task automatic send_serial(input logic [7:0] b, input logic stop);
      for (int j = 0; j < 10; j++) begin
         ext_rxin = (j == 9) ? stop : frame_bit(b, j);
         #(BIT_NS);
      end
      ext_rxin = 1'b1;
   endtask

   initial begin
      logic [7:0] q[$];
      logic [7:0] b, prev;
      int line_err, act_err, done_at, done_cnt, base, seen;
      int unsigned t_done, t_last;

      repeat (3) @(negedge clk);
      check("rst_lb_txd",    32'(lb_txd), 32'd1);
      check("rst_lb_active", 32'(lb_active), 32'd0);
      check("rst_lb_txdone", 32'(lb_txdone), 32'd0);
      check("rst_lb_rxdone", 32'(lb_rxdone), 32'd0);
      check("rst_lb_rxbyte", 32'(lb_rxbyte), 32'h00);
      check("rst_ext_txd",   32'(ext_txd), 32'd1);
      check("rst_ext_rxbyte",32'(ext_rxbyte), 32'h00);
      reset = 1'b0;
      repeat (4) @(negedge clk);

      // Single TX frame of 8'h55, cycle-accurate line check; byte changed after latch
      base = lb_rx_cnt;
      lb_byte = 8'h55; lb_ready = 1'b1;
      @(negedge clk);
      lb_ready = 1'b0; lb_byte = 8'hFF;
      line_err = 0; act_err = 0; done_at = 0; done_cnt = 0;
      for (int k = 1; k <= int'(FRAME) + 1; k++) begin
         if (k <= int'(FRAME)) begin
            if (lb_txd !== frame_bit(8'h55, (k - 1) / int'(CPB))) line_err++;
            if (lb_active !== 1'b1) act_err++;
         end else begin
            if (lb_txd !== 1'b1) line_err++;
            if (lb_active !== 1'b0) act_err++;
         end
         if (lb_txdone === 1'b1) begin done_cnt++; done_at = k; end
         @(negedge clk);
      end
      check("tx55_line_errs",   32'(line_err), 32'd0);
      check("tx55_active_errs", 32'(act_err), 32'd0);
      check("tx55_done_clk",    32'(done_at), 32'(FRAME));
      check("tx55_done_pulses", 32'(done_cnt), 32'd1);
      repeat (10) @(negedge clk);
      check("lb55_rxbyte", 32'(lb_rxbyte), 32'h55);
      check("lb55_rxcnt",  32'(lb_rx_cnt - base), 32'd1);

      // Loopback stream with i_Tx_Ready held high
      q = '{8'h01, 8'h10, 8'h22, 8'h32, 8'h55, 8'hAA, 8'hAB, 8'h88};
      for (int i = 0; i < 4; i++) q.push_back(8'($urandom));
      base = lb_rx_cnt;
      t_last = 0;
      lb_byte = q[0]; lb_ready = 1'b1;
      for (int i = 0; i < q.size(); i++) begin
         seen = 0;
         for (int c = 0; c < 2 * int'(FRAME) && seen == 0; c++) begin
            @(negedge clk);
            if (lb_rxdone === 1'b1) seen = 1;
         end
         check("stream_rx_seen", 32'(seen), 32'd1);
         check("stream_rxbyte",  32'(lb_rxbyte), 32'(q[i]));
         if (i + 1 < q.size()) lb_byte = q[i + 1];
         else                  lb_ready = 1'b0;
         seen = 0; t_done = 0;
         for (int c = 0; c < 400 && seen == 0; c++) begin
            @(negedge clk);
            if (lb_txdone === 1'b1) begin seen = 1; t_done = cyc; end
         end
         check("stream_txdone_seen", 32'(seen), 32'd1);
         if (i > 0) check("stream_pitch", 32'(t_done - t_last), 32'(FRAME + 1));
         t_last = t_done;
      end
      repeat (5) @(negedge clk);
      check("stream_rxcnt",    32'(lb_rx_cnt - base), 32'(q.size()));
      check("stream_idle_act", 32'(lb_active), 32'd0);

      // External line: valid frames at 8680 ns per bit
      base = ext_rx_cnt;
      send_serial(8'h55, 1'b1);
      #(BIT_NS);
      check("ext55_rxbyte", 32'(ext_rxbyte), 32'h55);
      check("ext55_rxcnt",  32'(ext_rx_cnt - base), 32'd1);
      b = 8'h55;
      for (int i = 0; i < 3; i++) begin
         base = ext_rx_cnt;
         b = 8'($urandom);
         send_serial(b, 1'b1);
         #(BIT_NS);
         check("ext_rand_rxbyte", 32'(ext_rxbyte), 32'(b));
         check("ext_rand_rxcnt",  32'(ext_rx_cnt - base), 32'd1);
      end

      // 2 us low glitch must be rejected, then a valid frame still lands
      prev = b; base = ext_rx_cnt;
      ext_rxin = 1'b0; #2000; ext_rxin = 1'b1;
      #(BIT_NS * 12);
      check("glitch_rxcnt",  32'(ext_rx_cnt - base), 32'd0);
      check("glitch_rxbyte", 32'(ext_rxbyte), 32'(prev));
      b = 8'($urandom);
      send_serial(b, 1'b1);
      #(BIT_NS);
      check("post_glitch_rxbyte", 32'(ext_rxbyte), 32'(b));
      check("post_glitch_rxcnt",  32'(ext_rx_cnt - base), 32'd1);

      // Framing error: stop bit 0 gives no update, next frame received
      prev = b; base = ext_rx_cnt;
      send_serial(8'($urandom) ^ prev ^ 8'h5A, 1'b0);
      #(BIT_NS * 2);
      check("frerr_rxcnt",  32'(ext_rx_cnt - base), 32'd0);
      check("frerr_rxbyte", 32'(ext_rxbyte), 32'(prev));
      b = ~prev;
      send_serial(b, 1'b1);
      #(BIT_NS);
      check("post_frerr_rxbyte", 32'(ext_rxbyte), 32'(b));
      check("post_frerr_rxcnt",  32'(ext_rx_cnt - base), 32'd1);

      // Reset in the middle of a start bit: line returns high without a clock edge
      @(negedge clk);
      lb_byte = 8'h00; lb_ready = 1'b1;
      repeat (100) @(negedge clk);
      check("pre_reset_txd", 32'(lb_txd), 32'd0);
      #5 reset = 1'b1;
      #1;
      check("midrst_lb_txd",     32'(lb_txd), 32'd1);
      check("midrst_lb_active",  32'(lb_active), 32'd0);
      check("midrst_lb_txdone",  32'(lb_txdone), 32'd0);
      check("midrst_lb_rxdone",  32'(lb_rxdone), 32'd0);
      check("midrst_lb_rxbyte",  32'(lb_rxbyte), 32'h00);
      check("midrst_ext_rxbyte", 32'(ext_rxbyte), 32'h00);
      lb_ready = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);

      // Recovery after reset
      b = 8'($urandom);
      lb_byte = b; lb_ready = 1'b1;
      @(negedge clk);
      lb_ready = 1'b0;
      seen = 0;
      for (int c = 0; c < 2 * int'(FRAME) && seen == 0; c++) begin
         @(negedge clk);
         if (lb_rxdone === 1'b1) seen = 1;
      end
      check("recover_rx_seen", 32'(seen), 32'd1);
      check("recover_rxbyte",  32'(lb_rxbyte), 32'(b));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
